// File: rtl/i2s_tx_if.sv
// -----------------------------------------------------------------------------
// i2s_tx_if : bundle of the signals between the mixer, the I2S transmitter and
// the DAC pins.
//
// Handshake: sample_valid is a one-cycle strobe qualifying sample_in. There is
// no ready. The transmitter takes a sample on every cycle that sample_valid is
// high and never stalls the upstream side.
//
// Signals:
//   sample_in     DATA_WIDTH  two's-complement sample from the mixer
//   sample_valid  1           strobe, sample_in valid this cycle
//   clear_flags   1           clears the sticky underrun/overrun flags
//   bclk          1           I2S bit clock
//   lrclk         1           I2S word select (0 = left, 1 = right)
//   sdata         1           I2S serial data, MSB first
//   frame_start   1           one-clk pulse at each frame boundary
//   underrun      1           sticky: a frame started with no new sample
//   overrun       1           sticky: a buffered sample was overwritten
//
// Modports: master = sample source / flag consumer, slave = transmitter.
// -----------------------------------------------------------------------------
interface i2s_tx_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] sample_in;
  logic                  sample_valid;
  logic                  clear_flags;
  logic                  bclk;
  logic                  lrclk;
  logic                  sdata;
  logic                  frame_start;
  logic                  underrun;
  logic                  overrun;

  modport master (
    output sample_in, sample_valid, clear_flags,
    input  bclk, lrclk, sdata, frame_start, underrun, overrun
  );

  modport slave (
    input  sample_in, sample_valid, clear_flags,
    output bclk, lrclk, sdata, frame_start, underrun, overrun
  );
endinterface

// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx : I2S serial output stage. Buffers one mono sample, sends it on both
// channels of a standard I2S frame, derives bclk/lrclk from clk by an integer
// divider and pulses frame_start once per frame.
//
// Ports:
//   clk    system clock, all logic on the rising edge
//   reset  synchronous, active-low reset
//   bus    i2s_tx_if.slave (sample input, flag clear, I2S pins, status)
//
// Parameters:
//   DATA_WIDTH  sample width (<= SLOT_WIDTH)
//   SLOT_WIDTH  bclk periods per channel slot
//   BCLK_DIV    clk cycles per bclk half-period (>= 1)
// -----------------------------------------------------------------------------
module i2s_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_DIV   = 4
) (
  input  logic     clk,
  input  logic     reset,
  i2s_tx_if.slave  bus
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int P_W        = $clog2(FRAME_BITS);
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [P_W-1:0]        P_LAST   = P_W'(FRAME_BITS - 1);
  localparam logic [P_W-1:0]        P_SLOT   = P_W'(SLOT_WIDTH);
  localparam logic [P_W-1:0]        P_LR_LO  = P_W'(SLOT_WIDTH - 1);
  localparam logic [P_W-1:0]        P_LR_HI  = P_W'(FRAME_BITS - 2);
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DATA_WIDTH-1:0] MSB_MASK = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

  logic [DIV_W-1:0]      r_div_cnt;
  logic [P_W-1:0]        r_p;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_frame_word;
  logic                  r_pending;
  logic                  r_primed;
  logic                  r_bclk;
  logic                  r_lrclk;
  logic                  r_sdata;
  logic                  r_frame_start;
  logic                  r_underrun;
  logic                  r_overrun;

  logic                  w_tick;
  logic                  w_fall;
  logic                  w_load;
  logic [P_W-1:0]        w_p_next;
  logic [P_W-1:0]        w_q;
  logic [DATA_WIDTH-1:0] w_frame_next;
  logic                  w_sdata_next;
  logic                  w_lr_next;
  logic                  w_set_under;
  logic                  w_set_over;

  always_comb begin
    w_tick       = (r_div_cnt == DIV_LAST);
    // A falling bclk edge is a wrap while bclk is currently high.
    w_fall       = w_tick & r_bclk;
    w_p_next     = (r_p == P_LAST) ? '0 : r_p + P_W'(1);
    w_load       = w_fall & (w_p_next == '0);

    w_frame_next = r_frame_word;
    w_set_under  = 1'b0;
    w_set_over   = 1'b0;
    if (w_load) begin
      if (bus.sample_valid) begin
        // Bypass: a sample arriving on the load cycle goes straight out.
        w_frame_next = bus.sample_in;
        w_set_over   = r_pending;
      end else if (r_pending) begin
        w_frame_next = r_hold;
      end else begin
        w_set_under  = r_primed;
      end
    end else if (bus.sample_valid) begin
      w_set_over = r_pending;
    end

    // Bit position inside the slot; both slots carry the same word.
    w_q          = (w_p_next >= P_SLOT) ? w_p_next - P_SLOT : w_p_next;
    // Shifting left by q brings bit (DATA_WIDTH-1-q) to the MSB; q past the
    // word shifts everything out, giving the zero padding of the slot.
    w_sdata_next = |((w_frame_next << w_q) & MSB_MASK);
    // Word select changes one bit ahead of the slot it announces.
    w_lr_next    = (w_p_next >= P_LR_LO) && (w_p_next <= P_LR_HI);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div_cnt     <= '0;
      r_p           <= P_LAST;
      r_hold        <= '0;
      r_frame_word  <= '0;
      r_pending     <= 1'b0;
      r_primed      <= 1'b0;
      r_bclk        <= 1'b0;
      r_lrclk       <= 1'b0;
      r_sdata       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_div_cnt     <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      if (w_tick) begin
        r_bclk <= ~r_bclk;
      end
      r_frame_start <= w_load;

      if (w_fall) begin
        r_p     <= w_p_next;
        r_lrclk <= w_lr_next;
        r_sdata <= w_sdata_next;
      end

      if (w_load) begin
        r_frame_word <= w_frame_next;
        r_pending    <= 1'b0;
      end else if (bus.sample_valid) begin
        r_hold    <= bus.sample_in;
        r_pending <= 1'b1;
        r_primed  <= 1'b1;
      end

      // Set wins over a simultaneous clear.
      r_underrun <= (r_underrun & ~bus.clear_flags) | w_set_under;
      r_overrun  <= (r_overrun  & ~bus.clear_flags) | w_set_over;
    end
  end

  assign bus.bclk        = r_bclk;
  assign bus.lrclk       = r_lrclk;
  assign bus.sdata       = r_sdata;
  assign bus.frame_start = r_frame_start;
  assign bus.underrun    = r_underrun;
  assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx : directed self-checking bench for i2s_tx at default parameters
// (16-bit data, 32-bit slots, bclk_div 4: 8 clk per bit, 512 clk per frame).
// Captured frames are 64-bit vectors indexed by bit position p; a word w shows
// up as bit-reverse(w) in bits 0..15 and again in bits 32..47.
// -----------------------------------------------------------------------------
module tb_i2s_tx;

  localparam logic [63:0] LR_EXP = 64'h7FFF_FFFF_8000_0000;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [63:0] cap_sd;
  logic [63:0] cap_lr;

  i2s_tx_if #(.DATA_WIDTH(16)) bus ();

  i2s_tx #(.DATA_WIDTH(16), .SLOT_WIDTH(32), .BCLK_DIV(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic send_sample(input logic [15:0] w);
    bus.sample_in    = w;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear_flags = 1'b1;
    @(negedge clk);
    bus.clear_flags = 1'b0;
  endtask

  task automatic wait_fs();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_fs: frame_start not seen within 600 clk, required a pulse");
    end
  endtask

  // Called on the negedge right after a frame_start edge; samples each of
  // the 64 bits mid-bit and returns 8 clk before the next frame_start.
  task automatic capture_frame();
    for (int k = 0; k < 64; k++) begin
      cap_sd[k] = bus.sdata;
      cap_lr[k] = bus.lrclk;
      if (k < 63) repeat (8) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.sample_in = '0; bus.sample_valid = 1'b0; bus.clear_flags = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.bclk, bus.lrclk, bus.sdata, bus.frame_start, bus.underrun, bus.overrun} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 000000",
               {bus.bclk, bus.lrclk, bus.sdata, bus.frame_start, bus.underrun, bus.overrun});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.bclk !== 1'b0) begin errors++; $display("FAIL bclk_edge3: got %b required 0", bus.bclk); end
    @(negedge clk);
    checks++;
    if (bus.bclk !== 1'b1) begin errors++; $display("FAIL bclk_edge4: got %b required 1", bus.bclk); end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL fs_edge7: got %b required 0", bus.frame_start); end
    @(negedge clk);
    checks++;
    if ({bus.frame_start, bus.bclk} !== 2'b10) begin
      errors++; $display("FAIL fs_edge8: got fs,bclk=%b required 10", {bus.frame_start, bus.bclk});
    end
    @(negedge clk);
    checks++;
    if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL fs_edge9: got %b required 0", bus.frame_start); end
    repeat (510) @(negedge clk);
    checks++;
    if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL fs_edge519: got %b required 0", bus.frame_start); end
    @(negedge clk);
    checks++;
    if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL fs_edge520: got %b required 1", bus.frame_start); end
  endtask

  task automatic test_idle();
    capture_frame();
    checks++;
    if (cap_sd !== 64'h0) begin errors++; $display("FAIL idle_sdata: got %h required 0", cap_sd); end
    checks++;
    if (cap_lr !== LR_EXP) begin errors++; $display("FAIL idle_lrclk: got %h required %h", cap_lr, LR_EXP); end
    checks++;
    if (bus.underrun !== 1'b0) begin errors++; $display("FAIL idle_underrun: got %b required 0", bus.underrun); end
  endtask

  task automatic test_single();
    wait_fs();
    repeat (100) @(negedge clk);
    send_sample(16'h8001);
    wait_fs();
    capture_frame();
    checks++;
    if (cap_sd !== 64'h0000_8001_0000_8001) begin
      errors++; $display("FAIL single_sdata: got %h required 0000800100008001", cap_sd);
    end
    checks++;
    if (cap_lr !== LR_EXP) begin errors++; $display("FAIL single_lrclk: got %h required %h", cap_lr, LR_EXP); end
    checks++;
    if ({bus.underrun, bus.overrun} !== 2'b00) begin
      errors++; $display("FAIL single_flags: got ur,ov=%b required 00", {bus.underrun, bus.overrun});
    end
  endtask

  task automatic test_underrun();
    wait_fs();
    pulse_clear();
    checks++;
    if (bus.underrun !== 1'b0) begin errors++; $display("FAIL ur_clear_pre: got %b required 0", bus.underrun); end
    repeat (50) @(negedge clk);
    send_sample(16'h1234);
    wait_fs();
    checks++;
    if (bus.underrun !== 1'b0) begin errors++; $display("FAIL ur_loaded: got %b required 0", bus.underrun); end
    capture_frame();
    checks++;
    if (cap_sd !== 64'h0000_2C48_0000_2C48) begin
      errors++; $display("FAIL ur_first_sdata: got %h required 00002c4800002c48", cap_sd);
    end
    wait_fs();
    capture_frame();
    checks++;
    if (cap_sd !== 64'h0000_2C48_0000_2C48) begin
      errors++; $display("FAIL ur_repeat_sdata: got %h required 00002c4800002c48", cap_sd);
    end
    checks++;
    if (bus.underrun !== 1'b1) begin errors++; $display("FAIL ur_set: got %b required 1", bus.underrun); end
    pulse_clear();
    checks++;
    if (bus.underrun !== 1'b0) begin errors++; $display("FAIL ur_cleared: got %b required 0", bus.underrun); end
  endtask

  task automatic test_overrun();
    wait_fs();
    pulse_clear();
    repeat (20) @(negedge clk);
    send_sample(16'h1234);
    repeat (5) @(negedge clk);
    send_sample(16'h5678);
    checks++;
    if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ov_set: got %b required 1", bus.overrun); end
    wait_fs();
    capture_frame();
    checks++;
    if (cap_sd !== 64'h0000_1E6A_0000_1E6A) begin
      errors++; $display("FAIL ov_sdata: got %h required 00001e6a00001e6a", cap_sd);
    end
    checks++;
    if ({bus.underrun, bus.overrun} !== 2'b01) begin
      errors++; $display("FAIL ov_flags: got ur,ov=%b required 01", {bus.underrun, bus.overrun});
    end
  endtask

  task automatic test_reset_mid();
    wait_fs();
    repeat (50) @(negedge clk);
    send_sample(16'hABCD);
    repeat (109) @(negedge clk);
    checks++;
    if (bus.underrun !== 1'b1) begin errors++; $display("FAIL mid_pre_underrun: got %b required 1", bus.underrun); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.bclk, bus.lrclk, bus.sdata, bus.frame_start, bus.underrun, bus.overrun} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b required 000000",
               {bus.bclk, bus.lrclk, bus.sdata, bus.frame_start, bus.underrun, bus.overrun});
    end
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    checks++;
    if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL mid_fs_edge7: got %b required 0", bus.frame_start); end
    @(negedge clk);
    checks++;
    if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL mid_fs_edge8: got %b required 1", bus.frame_start); end
    capture_frame();
    checks++;
    if (cap_sd !== 64'h0) begin errors++; $display("FAIL mid_hold_discarded: got %h required 0", cap_sd); end
    checks++;
    if ({bus.underrun, bus.overrun} !== 2'b00) begin
      errors++; $display("FAIL mid_flags: got ur,ov=%b required 00", {bus.underrun, bus.overrun});
    end
  endtask

  task automatic test_bypass();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    bus.sample_in    = 16'h7FFF;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    checks++;
    if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL byp_fs: got %b required 1", bus.frame_start); end
    capture_frame();
    checks++;
    if (cap_sd !== 64'h0000_FFFE_0000_FFFE) begin
      errors++; $display("FAIL byp_sdata: got %h required 0000fffe0000fffe", cap_sd);
    end
    checks++;
    if ({bus.underrun, bus.overrun} !== 2'b00) begin
      errors++; $display("FAIL byp_flags: got ur,ov=%b required 00", {bus.underrun, bus.overrun});
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_idle();
    test_single();
    test_underrun();
    test_overrun();
    test_reset_mid();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Serial output stage for the DSP pipeline. Accepts the mono mixed sample (`out_sample` / `out_sample_ready` from the mixer), holds it in a one-deep buffer, and transmits it on both channels of a standard I2S frame to the DAC. Bit clock and word clock are generated from the single system clock by an integer divider. Each frame emits a one-cycle `frame_start` tick, usable as the pipeline's sample-rate strobe. Underrun and overrun are reported as sticky flags.

## Interface
- `data_width`, 16: sample width, two's complement; must be ≤ `slot_width`.
- `slot_width`, 32: bclk periods per channel slot (frame = 2·`slot_width` bits).
- `bclk_div`, 4: clk cycles per bclk half-period; ≥ 1.

Ports:
- `clk`  in  1: system clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `sample_in`  in  `data_width`: sample to transmit (mixer `out_sample`).
- `sample_valid`  in  1: one-cycle strobe, sample_in valid (mixer `out_sample_ready`).
- `clear_flags`  in  1: clears `underrun` and `overrun`.
- `bclk`  out  1: I2S bit clock.
- `lrclk`  out  1: I2S word select; 0 = left, 1 = right.
- `sdata`  out  1: I2S serial data, MSB first.
- `frame_start`  out  1: one-clk pulse at each frame boundary.
- `underrun`  out  1: sticky; a frame started with no new sample.
- `overrun`  out  1: sticky; a buffered sample was overwritten before transmission.

## Operation
- Registers: `div_cnt` (0..`bclk_div`-1), bit position `p` (0..2S-1, S = `slot_width`), `hold`, `pending`, `frame_word`, `primed`.
- Reset (`reset`=0 at a clk edge): `bclk`=0, `lrclk`=0, `sdata`=0, `frame_start`=0, `underrun`=0, `overrun`=0, `div_cnt`=0, `p`=2S-1, `hold`=0, `frame_word`=0, `pending`=0, `primed`=0. Reset overrides all other inputs, including mid-frame.
- Divider: `div_cnt` increments each clk. At `bclk_div`-1 it wraps to 0 and `bclk` toggles.
- Falling-edge event (toggle 1→0): `p` ← (`p`+1) mod 2S.
  - `lrclk` ← 1 for new `p` in S-1..2S-2, else 0. Word select thus leads data by one bit.
  - `sdata` ← bit (`data_width`-1-q) of the word, where q = `p` mod S and q < `data_width`; otherwise 0.
  - Both slots carry the same word. Data changes only on falling edges.
- Frame load (falling event with new `p`=0):
  - If `sample_valid` is asserted this cycle, `frame_word` ← `sample_in` (bypass). `pending` ← 0. If `pending` was already 1, set `overrun`.
  - Else if `pending`=1: `frame_word` ← `hold`, `pending` ← 0.
  - Else: `frame_word` unchanged (repeat). If `primed`=1, set `underrun`.
  - The MSB output at `p`=0 comes from the newly loaded word.
  - `frame_start`=1 for exactly this clk.
- Sample acceptance (non-load cycle): `sample_valid` → `hold` ← `sample_in`, `pending` ← 1, `primed` ← 1. If `pending` was already 1, set `overrun`; the latest sample wins.
- Flags are sticky until `clear_flags`. If a set event and `clear_flags` occur in the same cycle, set wins.

## Timing
- bclk period = 2·`bclk_div` clk. Frame = 4·S·`bclk_div` clk (512 at defaults, i.e. 48 kHz at 24.576 MHz).
- After reset release, the first rising bclk occurs at clk edge `bclk_div` and the first `frame_start` at clk edge 2·`bclk_div` (8 at defaults). After that, `frame_start` repeats every frame period.
- Input latency: a sample accepted anywhere in frame N is transmitted starting at frame N+1's `frame_start`. A sample coincident with `frame_start` is transmitted in that same frame.
- All outputs are registered; no combinational path from inputs to outputs.
- `sample_valid` needs no handshake; it is accepted every cycle. The block never stalls upstream.

## Test plan
- Idle after reset: `bclk` toggles every 4 clk. `frame_start` fires at clk 8, then every 512. `lrclk` is high during `p`=31..62. `sdata` stays 0. `underrun` stays 0 (not primed).
- Send 0x8001 mid-frame → the next frame's left bits `p`0..15 are 1,0×14,1, `p`16..31 are 0, and the right slot is identical. `underrun`=0, `overrun`=0.
- Send 0x1234 once, then nothing → the following frame repeats 0x1234 and `underrun`=1. Pulse `clear_flags` → `underrun`=0.
- Send 0x1234 then 0x5678 within one frame → the next frame carries 0x5678 and `overrun`=1.
- `sample_valid` with 0x7FFF on the exact `frame_start` clk → that frame carries 0x7FFF and `underrun` stays 0.
- Drive `reset`=0 at `p`=20 → the next clk shows all outputs at reset values. After release, `frame_start` is at clk 8 and the prior `hold` is discarded.
